// File: rtl/uart_imem_loader.sv
// uart_imem_loader: receives a framed program over UART 8N1 and
// writes it word by word into instruction memory, holding the CPU meanwhile.
module uart_imem_loader #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);

    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
    localparam logic [16:0]   DEPTH    = 17'(1 << ADDR_W);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [2:0] L_IDLE = 3'd0;
    localparam logic [2:0] L_CNT0 = 3'd1;
    localparam logic [2:0] L_CNT1 = 3'd2;
    localparam logic [2:0] L_DATA = 3'd3;
    localparam logic [2:0] L_DONE = 3'd4;

    logic          rx_meta;
    logic          rx_sync;
    logic [1:0]    r_state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    logic          stop_tick;
    logic          rx_valid;
    logic          frame_bad;
    logic [7:0]    rx_byte;

    logic [2:0]    l_state;
    logic [7:0]    cnt_lo;
    logic [15:0]   count;
    logic [15:0]   word_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   wbuf;
    logic          fin;
    logic          in_range;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Byte receiver: mid-bit sampling of start, 8 data bits and stop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= R_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (!rx_sync) r_state <= R_START;
                end
                R_START: begin
                    if (cnt == HALF_END) begin
                        cnt     <= '0;
                        r_state <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) r_state <= R_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        r_state <= R_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign stop_tick = (r_state == R_STOP) && (cnt == BIT_END);
    assign rx_valid  = stop_tick && rx_sync;
    assign frame_bad = stop_tick && !rx_sync;
    assign rx_byte   = shreg;
    assign in_range  = {1'b0, word_idx} < DEPTH;

    // Frame loader: header, count, then little-endian words into imem.
    always_ff @(posedge clk) begin
        if (!reset) begin
            l_state    <= L_IDLE;
            cnt_lo     <= '0;
            count      <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            wbuf       <= '0;
            fin        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            if (frame_bad) begin
                err      <= 1'b1;
                cpu_hold <= 1'b0;
                fin      <= 1'b0;
                l_state  <= L_IDLE;
            end else begin
                unique case (l_state)
                    L_IDLE: begin
                        if (rx_valid && rx_byte == 8'hA5) begin
                            l_state  <= L_CNT0;
                            cpu_hold <= 1'b1;
                        end
                    end
                    L_CNT0: begin
                        if (rx_valid) begin
                            cnt_lo  <= rx_byte;
                            l_state <= L_CNT1;
                        end
                    end
                    L_CNT1: begin
                        if (rx_valid) begin
                            count    <= {rx_byte, cnt_lo};
                            word_idx <= '0;
                            byte_idx <= '0;
                            fin      <= 1'b0;
                            if ({rx_byte, cnt_lo} == 16'd0) begin
                                l_state  <= L_DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                l_state <= L_DATA;
                            end
                        end
                    end
                    L_DATA: begin
                        if (fin) begin
                            // done trails the final write by one cycle
                            l_state  <= L_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            fin      <= 1'b0;
                        end else if (rx_valid) begin
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                if (in_range) begin
                                    imem_we    <= 1'b1;
                                    imem_addr  <= word_idx[ADDR_W-1:0];
                                    imem_wdata <= {rx_byte, wbuf};
                                end
                                word_idx <= word_idx + 16'd1;
                                fin      <= (word_idx == count - 16'd1);
                            end else begin
                                wbuf <= {rx_byte, wbuf[23:8]};
                            end
                        end
                    end
                    L_DONE: l_state <= L_IDLE;
                    default: l_state <= L_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_imem_loader.md
# uart_imem_loader

Board-level program loader that receives a MIPS program over a UART RX line and writes it word by word into the CPU's instruction memory. It holds the CPU stopped while loading, so new programs can be run without re-synthesis. It sits in the board top next to the debounce and display logic. It is the write/input counterpart of the instruction-fetch/display path: the CPU reads instruction memory, and this block fills it.

## Interface
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- BAUD, 115200: UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division).
- ADDR_W, 8: instruction memory word-address width (depth 2^ADDR_W words).

- clk  in  1  board clock; all logic rising-edge.
- reset  in  1  synchronous, active-low reset.
- rx  in  1  UART receive line (idle high, 8N1, LSB first); asynchronous to clk.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  write data.
- cpu_hold  out  1  high while a load is in progress; top ORs it into CPU reset/stall.
- done  out  1  one-cycle pulse at end of a successful load.
- err  out  1  sticky framing-error flag; cleared only by reset.

## Operation
- rx passes through a 2-flop synchronizer (reset value 1) before any use.
- The byte receiver FSM has states R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: on synced rx = 0, go to R_START and clear the bit counter.
  - R_START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is 1, it is a false start: return to R_IDLE with no byte. If 0, go to R_DATA.
  - R_DATA: sample every CLKS_PER_BIT cycles. Shift in 8 bits, LSB first.
  - R_STOP: sample after CLKS_PER_BIT. If 1, emit rx_valid (internal, one cycle) with the byte. If 0, set err, discard the byte, and force the loader FSM to L_IDLE. Return to R_IDLE in both cases.
- Frame protocol (bytes): 0xA5, CNT_LO, CNT_HI, then N = {CNT_HI, CNT_LO} words of 4 bytes each, little-endian (first byte goes to wdata[7:0]).
- The loader FSM has states L_IDLE, L_CNT0, L_CNT1, L_DATA, L_DONE.
  - L_IDLE: ignore all bytes except 0xA5. On 0xA5, go to L_CNT0 and set cpu_hold.
  - L_CNT0 latches CNT_LO. L_CNT1 latches CNT_HI.
  - After L_CNT1: if N = 0, go to L_DONE; otherwise go to L_DATA with word index 0 and byte index 0.
  - L_DATA assembles bytes. On the 4th byte, issue the write at address word_index[ADDR_W-1:0], then increment word index. After word N-1, go to L_DONE.
  - Words with index ≥ 2^ADDR_W are consumed but not written: imem_we stays low and there is no address wrap.
  - L_DONE lasts one cycle: done = 1, cpu_hold cleared, then L_IDLE.
- Once in L_DATA, a byte 0xA5 is data, not a restart.
- Reset mid-load: all state clears. Memory keeps any words already written.

## Timing
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, err=0, both FSMs idle.
- rx_valid asserts (CLKS_PER_BIT/2) + 9·CLKS_PER_BIT cycles after the synced falling edge, plus 2 cycles of synchronizer delay.
- cpu_hold rises the cycle after rx_valid for 0xA5.
- imem_we/addr/wdata are registered. They are valid together for exactly one cycle, the cycle after rx_valid of the word's 4th byte. imem_addr and imem_wdata hold their values afterward.
- done pulses the cycle after the last write, or the cycle after rx_valid of CNT_HI when N = 0. cpu_hold falls in that same cycle.
- A framing error sets err the cycle after the stop sample. If a load was active, cpu_hold falls in that same cycle and no done is issued.
- Back-to-back frames with no idle gap are received without loss.

## Test plan
Benches use CLK_FREQ=160, BAUD=10 (CLKS_PER_BIT=16).
- Reset: hold reset=0 for 5 cycles with rx=1. All outputs are 0, and no activity follows reset release.
- Basic load: send A5 02 00 78 56 34 12 EF BE AD DE. Two imem_we pulses occur: addr 0 with 0x12345678, then addr 1 with 0xDEADBEEF. cpu_hold is high from after the A5 until done. One done pulse.
- Zero count: send A5 00 00. No imem_we; done pulses; cpu_hold is high for exactly the span between the A5 and CNT_HI bytes.
- Noise and errors:
  - Send byte 0x3C in L_IDLE, then an 8-cycle low glitch on rx. No state change and no err.
  - Then send a byte whose stop bit is 0. err=1, and the loader returns to idle.
- Overflow (ADDR_W=2): send N=5 words. Writes occur at addresses 0–3 only, the 5th word is consumed silently, and done pulses once.
- Reset mid-load: assert reset after 2 of 3 words. No further imem_we; cpu_hold=0. A following full frame then loads correctly from address 0.
